// File: rtl/warp_launch_ctrl.sv
// Warp launch controller: launches N warps one per cycle from a host Start,
// tracks live warps through EXIT decodes, and reports completion to the host.
module warp_launch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start_Host_TM,
    input  logic [3:0]  NumWarps_Host_TM,
    input  logic [31:0] StartingPC_Host_TM,
    input  logic        Exit_ID0_TM,
    input  logic        Exit_ID1_TM,
    input  logic [7:0]  Valid_ID0_TM,
    input  logic [7:0]  Valid_ID1_TM,
    output logic [2:0]  WarpID_TM_PC,
    output logic        UpdatePC_TM_PC,
    output logic [31:0] StartingPC_TM_PC,
    output logic [7:0]  ActiveMask_TM,
    output logic        Busy_TM_Host,
    output logic        Done_TM_Host,
    output logic        Error_TM_Host,
    output logic [31:0] CycleCount_TM_Host
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  num_q, num_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] cyc_q, cyc_d;
    logic [2:0]  wid_q, wid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        err_q, err_d;
    logic [7:0]  exit_clr;
    logic [31:0] cyc_inc;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        pc_d     = pc_q;
        mask_d   = mask_q;
        cyc_d    = cyc_q;
        wid_d    = wid_q;
        pc_out_d = pc_out_q;
        err_d    = 1'b0;

        exit_clr = ({8{Exit_ID0_TM}} & Valid_ID0_TM) | ({8{Exit_ID1_TM}} & Valid_ID1_TM);
        cyc_inc  = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (Start_Host_TM) begin
                    if (NumWarps_Host_TM != 4'd0 && NumWarps_Host_TM <= 4'd8) begin
                        num_d   = NumWarps_Host_TM;
                        pc_d    = StartingPC_Host_TM;
                        cnt_d   = 3'd0;
                        cyc_d   = 32'd0;
                        state_d = LAUNCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                // Clear before set: an exit aimed at the warp launching this
                // cycle targets a bit that is not yet live and is dropped.
                mask_d = (mask_q & ~exit_clr) | (8'd1 << cnt_q);
                cnt_d  = cnt_q + 3'd1;
                cyc_d  = cyc_inc;
                if ({1'b0, cnt_q} == num_q - 4'd1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mask_d = mask_q & ~exit_clr;
                cyc_d  = cyc_inc;
                if (mask_d == 8'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // PC-init outputs are loaded one cycle ahead so they are registered
        // while UpdatePC is high, and simply hold otherwise.
        if (state_d == LAUNCH) begin
            wid_d    = cnt_d;
            pc_out_d = pc_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            // rst_n is active-high despite its name.
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            num_q    <= 4'd0;
            pc_q     <= 32'd0;
            mask_q   <= 8'd0;
            cyc_q    <= 32'd0;
            wid_q    <= 3'd0;
            pc_out_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            pc_q     <= pc_d;
            mask_q   <= mask_d;
            cyc_q    <= cyc_d;
            wid_q    <= wid_d;
            pc_out_q <= pc_out_d;
            err_q    <= err_d;
        end
    end

    assign WarpID_TM_PC       = wid_q;
    assign UpdatePC_TM_PC     = (state_q == LAUNCH);
    assign StartingPC_TM_PC   = pc_out_q;
    assign ActiveMask_TM      = mask_q;
    assign Busy_TM_Host       = (state_q == LAUNCH) || (state_q == RUN);
    assign Done_TM_Host       = (state_q == DONE);
    assign Error_TM_Host      = err_q;
    assign CycleCount_TM_Host = cyc_q;

endmodule

// File: tb/tb_warp_launch_ctrl.sv
// Testbench for warp_launch_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a kernel-age based reference model.
module tb_warp_launch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  nw;
    logic [31:0] spc;
    logic        e0, e1;
    logic [7:0]  v0, v1;

    logic [2:0]  wid;
    logic        upd;
    logic [31:0] opc;
    logic [7:0]  mask;
    logic        busy, done, err;
    logic [31:0] cc;

    warp_launch_ctrl dut (
        .clk                (clk),
        .rst_n              (rst),
        .Start_Host_TM      (start),
        .NumWarps_Host_TM   (nw),
        .StartingPC_Host_TM (spc),
        .Exit_ID0_TM        (e0),
        .Exit_ID1_TM        (e1),
        .Valid_ID0_TM       (v0),
        .Valid_ID1_TM       (v1),
        .WarpID_TM_PC       (wid),
        .UpdatePC_TM_PC     (upd),
        .StartingPC_TM_PC   (opc),
        .ActiveMask_TM      (mask),
        .Busy_TM_Host       (busy),
        .Done_TM_Host       (done),
        .Error_TM_Host      (err),
        .CycleCount_TM_Host (cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  wid;
        logic        upd;
        logic [31:0] pc;
        logic [7:0]  mask;
        logic        busy;
        logic        done;
        logic        err;
        logic [31:0] cc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a kernel is "live" from the cycle after Start; its age
    // is the number of cycles since Start. Warp k launches at age k+1.
    bit          live    = 0;
    bit          in_done = 0;
    int          age     = 0;
    int          n       = 0;
    logic [31:0] mpc     = '0;
    logic [7:0]  mmask   = '0;
    logic [31:0] mcc     = '0;
    logic [2:0]  mwid    = '0;
    logic [31:0] mopc    = '0;

    task automatic model_edge();
        exp_t        e;
        bit          new_done = 0;
        bit          new_err  = 0;
        logic [7:0]  clr;
        if (rst) begin
            live  = 0;
            age   = 0;
            mmask = '0;
            mcc   = '0;
            mwid  = '0;
            mopc  = '0;
        end else if (live) begin
            clr = '0;
            if (e0) clr = clr | v0;
            if (e1) clr = clr | v1;
            mmask = mmask & ~clr;
            if (age <= n) mmask[age-1] = 1'b1;
            if (mcc != 32'hFFFF_FFFF) mcc = mcc + 1;
            if (age > n && mmask == 8'd0) begin
                live     = 0;
                new_done = 1;
            end
            age++;
        end else if (!in_done && start) begin
            if (nw >= 1 && nw <= 8) begin
                live = 1;
                age  = 1;
                n    = int'(nw);
                mpc  = spc;
                mcc  = '0;
            end else begin
                new_err = 1;
            end
        end
        in_done = new_done;
        e.upd = live && age >= 1 && age <= n;
        if (e.upd) begin
            mwid = 3'(age - 1);
            mopc = mpc;
        end
        e.wid  = mwid;
        e.pc   = mopc;
        e.mask = mmask;
        e.busy = live;
        e.done = new_done;
        e.err  = new_err;
        e.cc   = mcc;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: DUT presents a full output set every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("update_pc",   32'(upd),  32'(e.upd));
            check("warp_id",     32'(wid),  32'(e.wid));
            check("starting_pc", opc,       e.pc);
            check("active_mask", 32'(mask), 32'(e.mask));
            check("busy",        32'(busy), 32'(e.busy));
            check("done",        32'(done), 32'(e.done));
            check("error",       32'(err),  32'(e.err));
            check("cycle_count", cc,        e.cc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        start = 0;
        e0 = 0; e1 = 0;
        v0 = '0; v1 = '0;
    endtask

    task automatic launch(input logic [3:0] num, input logic [31:0] pc);
        idle_in();
        start = 1; nw = num; spc = pc;
        cyc();
        start = 0;
    endtask

    task automatic exits(input logic x0, input int w0, input logic x1, input int w1);
        e0 = x0; v0 = 8'd1 << w0;
        e1 = x1; v1 = 8'd1 << w1;
    endtask

    task automatic idle_cycles(input int k);
        idle_in();
        for (int i = 0; i < k; i++) cyc();
    endtask

    initial begin
        rst = 1; nw = 4'd0; spc = '0;
        idle_in();
        cyc(); cyc();
        rst = 0;
        idle_cycles(2);

        // Three warps from 0x100; two slots exit different warps together.
        launch(4'd3, 32'h100);
        idle_cycles(4);
        exits(1, 0, 1, 2); cyc();
        idle_cycles(1);
        exits(1, 1, 0, 0); cyc();
        idle_cycles(3);

        // Illegal counts.
        launch(4'd0, 32'h200);
        idle_cycles(2);
        launch(4'd9, 32'h300);
        idle_cycles(2);
        launch(4'd15, 32'h300);
        idle_cycles(2);

        // Start during RUN is dropped; same-warp exit on both slots.
        launch(4'd2, 32'hABC0);
        idle_cycles(3);
        launch(4'd4, 32'hDEAD);
        exits(1, 0, 1, 0); cyc();
        exits(1, 1, 0, 5); cyc();
        idle_cycles(1);
        launch(4'd2, 32'h4444);
        idle_cycles(3);
        exits(1, 1, 1, 0); cyc();
        idle_cycles(3);

        // Reset on the fifth of eight launch cycles, then immediate Start.
        launch(4'd8, 32'h8000);
        idle_cycles(4);
        rst = 1; cyc();
        rst = 0;
        launch(4'd2, 32'h9000);
        idle_cycles(3);
        exits(1, 0, 1, 1); cyc();
        idle_cycles(3);

        // Single warp exiting during its own launch cycle, then for real.
        launch(4'd1, 32'h1234);
        exits(1, 0, 0, 0); cyc();
        idle_cycles(2);
        exits(1, 0, 0, 0); cyc();
        idle_cycles(3);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            nw    = 4'($urandom_range(0, 10));
            spc   = $urandom;
            e0    = ($urandom_range(0, 3) == 0);
            e1    = ($urandom_range(0, 3) == 0);
            v0    = 8'd1 << $urandom_range(0, 7);
            v1    = ($urandom_range(0, 3) == 0) ? v0 : 8'd1 << $urandom_range(0, 7);
            rst   = ($urandom_range(0, 249) == 0);
            cyc();
        end
        rst = 0;
        idle_cycles(4);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/warp_launch_ctrl.md
WARP_LAUNCH_CTRL -- requirements
Module: warp_launch_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst_n, which is synchronous and active-high (asserted = 1).
REQ-002 The ports SHALL be, in this order (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-high reset.
- Start_Host_TM  in  1  kernel launch request, sampled each cycle.
- NumWarps_Host_TM  in  4  number of warps to launch; legal range 1..8.
- StartingPC_Host_TM  in  32  kernel entry PC, shared by all warps.
- Exit_ID0_TM  in  1  EXIT decoded in decode slot 0.
- Exit_ID1_TM  in  1  EXIT decoded in decode slot 1.
- Valid_ID0_TM  in  8  one-hot warp ID for decode slot 0.
- Valid_ID1_TM  in  8  one-hot warp ID for decode slot 1.
- WarpID_TM_PC  out  3  warp whose PC is being initialised.
- UpdatePC_TM_PC  out  1  PC initialisation strobe.
- StartingPC_TM_PC  out  32  PC value to load.
- ActiveMask_TM  out  8  warps launched and not yet exited.
- Busy_TM_Host  out  1  kernel in progress.
- Done_TM_Host  out  1  one-cycle kernel-completion pulse.
- Error_TM_Host  out  1  one-cycle illegal-launch pulse.
- CycleCount_TM_Host  out  32  kernel duration in cycles.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, LAUNCH, RUN and DONE.
REQ-004 In IDLE, Start=1 with NumWarps in 1..8 SHALL latch NumWarps and StartingPC, clear the launch counter to 0, clear CycleCount to 0, and move to LAUNCH.
REQ-005 In IDLE, Start=1 with NumWarps=0 or NumWarps>8 SHALL pulse Error_TM_Host for the next cycle and keep the FSM in IDLE.
REQ-006 In each LAUNCH cycle:
- UpdatePC_TM_PC=1, WarpID_TM_PC=launch counter, StartingPC_TM_PC=latched PC.
- ActiveMask[counter] set at the end of the cycle.
- counter incremented; when counter = N-1, move to RUN.
REQ-007 Warp k's strobe SHALL occur exactly k+1 cycles after the Start cycle; LAUNCH SHALL last exactly N cycles.
REQ-008 Outside LAUNCH, UpdatePC_TM_PC SHALL be 0 and WarpID_TM_PC / StartingPC_TM_PC SHALL hold their last driven values.
REQ-009 In LAUNCH and RUN, each slot s with Exit_IDs=1 SHALL clear the ActiveMask bits selected by Valid_IDs.
REQ-010 Exit conditions:
- Both slots exiting different warps in the same cycle SHALL clear both bits.
- Both slots exiting the same warp SHALL clear that bit once.
- An exit for a bit that is not set SHALL be ignored.
- An exit in IDLE or DONE SHALL be ignored.
REQ-011 In RUN, when the next-state ActiveMask is all zero, the FSM SHALL move to DONE.
REQ-012 In DONE, Done_TM_Host=1 for exactly one cycle, after which the FSM SHALL move to IDLE.
REQ-013 Busy_TM_Host SHALL be 1 exactly in LAUNCH and RUN.
REQ-014 Start SHALL be ignored in LAUNCH, RUN and DONE; it is not queued.
REQ-015 CycleCount SHALL increment by 1 every cycle in LAUNCH and RUN, saturate at 0xFFFFFFFF, and hold its value in DONE and IDLE until the next legal Start.
REQ-016 All outputs SHALL be derived from registered state only, with no combinational path from any input to any output.

Reset
REQ-017 rst_n=1 at a clock edge SHALL force, regardless of state:
- FSM to IDLE and launch counter to 0.
- ActiveMask, CycleCount, WarpID_TM_PC and StartingPC_TM_PC to 0.
- UpdatePC_TM_PC, Busy_TM_Host, Done_TM_Host and Error_TM_Host to 0.
REQ-018 Reset in mid-LAUNCH or mid-RUN SHALL abort the kernel with no Done pulse; a Start in the cycle after reset release SHALL be honoured.

Verification
REQ-019 Start, N=3, PC=0x100 at cycle t -> UpdatePC=1 at t+1..t+3 with WarpID 0,1,2 and PC 0x100; ActiveMask=0x07 at t+4; Busy=1 from t+1.
REQ-020 With N=3 running, slot 0 exits warp 0 and slot 1 exits warp 2 in the same cycle, then warp 1 exits at cycle e -> mask 0x02, then 0x00; Done=1 at e+1; Busy=0 at e+1.
REQ-021 Start with N=0 and, separately, with N=9 -> Error=1 for one cycle; no UpdatePC; FSM stays in IDLE.
REQ-022 Start asserted during RUN, then a new Start after Done -> first Start ignored; second launches normally; CycleCount restarts from 0.
REQ-023 N=8, reset asserted on the 5th LAUNCH cycle -> next cycle: mask=0, Busy=0, UpdatePC=0, no Done.
REQ-024 N=1 with warp 0 exiting during its own LAUNCH cycle, then a later exit of warp 0 -> bit 0 is set, the later exit clears it, Done follows one cycle after that exit.
